// File: rtl/pool_unit_if.sv
// Pixel stream in / pooled result out bundle for pool_unit.
// The slave side is the pooling engine; the master side is the pixel source and result sink.
interface pool_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              ce;
  logic              avg_mode;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_op;
  logic              end_op;

  modport master (output ce, avg_mode, data_in, input data_out, valid_op, end_op);
  modport slave  (input ce, avg_mode, data_in, output data_out, valid_op, end_op);
endinterface

// File: rtl/pool_unit.sv
// Streaming non-overlapping POOLxPOOL max/average pooler over a raster pixel stream.
// Per-window partial results for the current window row live in a line buffer of OUT_W entries.
//
// state  | meaning
// IDLE   | no pixel accepted yet this frame; avg_mode is taken live from the bus
// ACTIVE | frame in progress; mode is frozen in mode_q
module pool_unit #(
  parameter int DATA_W    = 32,
  parameter int IMG_W     = 12,
  parameter int IMG_H     = 12,
  parameter int POOL      = 3,
  parameter int AVG_SHIFT = 3
) (
  input  logic       clk,
  input  logic       master_rst,
  pool_unit_if.slave bus
);
  localparam int OUT_W = IMG_W / POOL;
  localparam int OUT_H = IMG_H / POOL;
  localparam int ACC_W = DATA_W + $clog2(POOL * POOL);
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int PW    = $clog2(POOL);
  localparam int OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LIM      = CW'(OUT_W * POOL);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_LIM      = RW'(OUT_H * POOL);
  localparam logic [RW-1:0] ROW_WIN_LAST = RW'(OUT_H * POOL - 1);
  localparam logic [PW-1:0] P_LAST       = PW'(POOL - 1);
  localparam logic [OW-1:0] OCOL_LAST    = OW'(OUT_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state, state_nxt;
  logic                     mode_q;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [PW-1:0]            hpos, vpos;
  logic [OW-1:0]            ocol;
  logic signed [ACC_W-1:0]  hacc;
  logic signed [ACC_W-1:0]  lb [OUT_W];
  logic [DATA_W-1:0]        data_out_q;
  logic                     valid_q, end_q;

  logic                     cur_avg, acc_en, frame_last, row_end;
  logic                     win_end, win_done, last_win;
  logic signed [ACC_W-1:0]  din_ext, h, w, shifted, sat_val;
  logic [DATA_W-1:0]        out_val;

  function automatic logic signed [ACC_W-1:0] combine(input logic avg,
                                                      input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return avg ? (a + b) : ((a > b) ? a : b);
  endfunction

  always_comb begin
    cur_avg    = (state == IDLE) ? bus.avg_mode : mode_q;
    din_ext    = {{(ACC_W-DATA_W){bus.data_in[DATA_W-1]}}, bus.data_in};
    acc_en     = (col < COL_LIM) && (row < ROW_LIM);
    row_end    = (col == COL_LAST);
    frame_last = row_end && (row == ROW_LAST);
    h          = (hpos == '0) ? din_ext : combine(cur_avg, hacc, din_ext);
    w          = combine(cur_avg, lb[ocol], h);
    shifted    = w >>> AVG_SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX;
    else if (shifted < SAT_MIN) sat_val = SAT_MIN;
    else                        sat_val = shifted;
    out_val    = cur_avg ? DATA_W'(sat_val) : DATA_W'(w);
    win_end    = bus.ce && acc_en && (hpos == P_LAST);
    win_done   = win_end && (vpos == P_LAST);
    last_win   = win_done && (row == ROW_WIN_LAST) && (ocol == OCOL_LAST);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ce && !frame_last) state_nxt = ACTIVE;
      ACTIVE:  if (bus.ce && frame_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      col        <= '0;
      row        <= '0;
      hpos       <= '0;
      vpos       <= '0;
      ocol       <= '0;
      hacc       <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      if (bus.ce) begin
        if (state == IDLE) mode_q <= bus.avg_mode;
        if (acc_en) hacc <= h;
        // Trailing columns/rows still step the counters so the raster position stays exact.
        if (row_end) begin
          col  <= '0;
          hpos <= '0;
          ocol <= '0;
          if (row == ROW_LAST) begin
            row  <= '0;
            vpos <= '0;
          end else begin
            row  <= row + 1'b1;
            vpos <= (vpos == P_LAST) ? '0 : vpos + 1'b1;
          end
        end else begin
          col  <= col + 1'b1;
          hpos <= (hpos == P_LAST) ? '0 : hpos + 1'b1;
          if (win_end) ocol <= (ocol == OCOL_LAST) ? '0 : ocol + 1'b1;
        end
      end
      if (win_done) begin
        data_out_q <= out_val;
        valid_q    <= 1'b1;
        end_q      <= last_win;
      end
    end
  end

  // Every window row starts with vpos=0, which overwrites the entry, so no reset is needed.
  always_ff @(posedge clk) begin
    if (win_end && (vpos != P_LAST)) lb[ocol] <= (vpos == '0) ? h : w;
  end

  assign bus.data_out = data_out_q;
  assign bus.valid_op = valid_q;
  assign bus.end_op   = end_q;
endmodule

// File: tb/tb_pool_unit.sv
// Bench for pool_unit: fixed vector table on three geometries, randomized frames against a
// window-level reference model, and a mid-frame reset sequence.
module tb_pool_unit;
  logic        clk = 1'b0;
  logic        master_rst = 1'b1;
  logic        ce = 1'b0;
  logic        avg_mode = 1'b0;
  logic [31:0] data_in = '0;
  int          sel = 0;

  logic [31:0] dout;
  logic        vo, eo;

  int cfg_w  [3] = '{12, 4, 5};
  int cfg_h  [3] = '{12, 4, 5};
  int cfg_p  [3] = '{3, 2, 2};
  int cfg_sh [3] = '{3, 2, 2};

  int n_vec = 0;
  int n_err = 0;

  int stim[$];
  int obs_val[$];
  bit obs_end[$];
  int exp_val[$];
  bit exp_end[$];

  always #5 clk = ~clk;

  pool_unit_if #(.DATA_W(32)) if0 ();
  pool_unit_if #(.DATA_W(32)) if1 ();
  pool_unit_if #(.DATA_W(32)) if2 ();

  assign if0.ce = ce && (sel == 0);
  assign if1.ce = ce && (sel == 1);
  assign if2.ce = ce && (sel == 2);
  assign if0.avg_mode = avg_mode;
  assign if1.avg_mode = avg_mode;
  assign if2.avg_mode = avg_mode;
  assign if0.data_in = data_in;
  assign if1.data_in = data_in;
  assign if2.data_in = data_in;

  pool_unit #(.DATA_W(32), .IMG_W(12), .IMG_H(12), .POOL(3), .AVG_SHIFT(3))
    u0 (.clk(clk), .master_rst(master_rst), .bus(if0.slave));
  pool_unit #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .POOL(2), .AVG_SHIFT(2))
    u1 (.clk(clk), .master_rst(master_rst), .bus(if1.slave));
  pool_unit #(.DATA_W(32), .IMG_W(5), .IMG_H(5), .POOL(2), .AVG_SHIFT(2))
    u2 (.clk(clk), .master_rst(master_rst), .bus(if2.slave));

  always_comb begin
    dout = if0.data_out;
    vo   = if0.valid_op;
    eo   = if0.end_op;
    case (sel)
      1: begin dout = if1.data_out; vo = if1.valid_op; eo = if1.end_op; end
      2: begin dout = if2.data_out; vo = if2.valid_op; eo = if2.end_op; end
      default: ;
    endcase
  end

  // A stray end_op without valid_op also lands here and shows up as an extra result.
  always @(negedge clk) begin
    if (vo || eo) begin
      obs_val.push_back(int'(dout));
      obs_end.push_back(eo);
    end
  end

  typedef struct {
    int sel;
    bit mode;
    int pat;
    int nexp;
    int e[4];
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string name, int idx, longint act, longint expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, expv);
    end
  endtask

  task automatic gen_pat(int s, int pat);
    int w, h, p, v, r, c, wr, wc;
    w = cfg_w[s]; h = cfg_h[s]; p = cfg_p[s];
    stim.delete();
    for (int i = 0; i < w * h; i++) begin
      r = i / w; c = i % w; wr = r / p; wc = c / p;
      case (pat)
        0: v = i;
        1: begin
          v = -5;
          if (wr < h / p && wc < w / p && (r % p) * p + (c % p) == (wr * 3 + wc) % (p * p)) v = 7;
        end
        default: v = -5;
      endcase
      stim.push_back(v);
    end
  endtask

  task automatic gen_rand(int n);
    stim.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) stim.push_back(int'($urandom));
      else stim.push_back(int'($urandom_range(2000)) - 1000);
    end
  endtask

  // Reference: walk every complete window of a frame directly in 2-D.
  task automatic build_expected(int s, bit m, int base);
    int w, h, p, ow, oh, v;
    longint sum, mx, q;
    w = cfg_w[s]; h = cfg_h[s]; p = cfg_p[s];
    ow = w / p; oh = h / p;
    for (int wr = 0; wr < oh; wr++) begin
      for (int wc = 0; wc < ow; wc++) begin
        sum = 0;
        mx = -(64'sd1 << 40);
        for (int dy = 0; dy < p; dy++) begin
          for (int dx = 0; dx < p; dx++) begin
            v = stim[base + (wr * p + dy) * w + wc * p + dx];
            sum += longint'(v);
            if (longint'(v) > mx) mx = longint'(v);
          end
        end
        if (m) begin
          q = sum >>> cfg_sh[s];
          if (q > 64'sd2147483647) q = 64'sd2147483647;
          if (q < -64'sd2147483648) q = -64'sd2147483648;
        end else begin
          q = mx;
        end
        exp_val.push_back(int'(q));
        exp_end.push_back(wr == oh - 1 && wc == ow - 1);
      end
    end
  endtask

  task automatic drive(int idle_pct, int t1, int t2);
    int gaps;
    for (int i = 0; i < stim.size(); i++) begin
      gaps = 0;
      while (idle_pct > 0 && gaps < 16 && $urandom_range(99) < idle_pct) begin
        ce = 1'b0;
        @(posedge clk); #1;
        gaps++;
      end
      ce = 1'b1;
      data_in = stim[i];
      if (i == t1 || i == t2) avg_mode = ~avg_mode;
      @(posedge clk); #1;
    end
    ce = 1'b0;
  endtask

  task automatic settle();
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    obs_val.delete(); obs_end.delete();
    exp_val.delete(); exp_end.delete();
  endtask

  task automatic check_frame(string tag);
    int n;
    chk({tag, ".count"}, 0, obs_val.size(), exp_val.size());
    n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, ".data"}, k, obs_val[k], exp_val[k]);
      chk({tag, ".end"}, k, obs_end[k], exp_end[k]);
    end
    clear_q();
  endtask

  initial begin
    tbl[0] = '{1, 1'b0, 0, 4, '{5, 7, 13, 15}};
    tbl[1] = '{1, 1'b1, 0, 4, '{2, 4, 10, 12}};
    tbl[2] = '{0, 1'b0, 1, 16, '{7, 0, 0, 0}};
    tbl[3] = '{0, 1'b0, 2, 16, '{-5, 0, 0, 0}};
    tbl[4] = '{0, 1'b1, 2, 16, '{-6, 0, 0, 0}};
    tbl[5] = '{2, 1'b0, 0, 4, '{6, 8, 16, 18}};

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst.data_out", s, dout, 0);
      chk("rst.valid_op", s, vo, 0);
      chk("rst.end_op", s, eo, 0);
    end
    master_rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      sel = tbl[t].sel;
      avg_mode = tbl[t].mode;
      gen_pat(tbl[t].sel, tbl[t].pat);
      clear_q();
      for (int k = 0; k < tbl[t].nexp; k++) begin
        exp_val.push_back((tbl[t].nexp == 16) ? tbl[t].e[0] : tbl[t].e[k]);
        exp_end.push_back(k == tbl[t].nexp - 1);
      end
      drive(0, -1, -1);
      settle();
      check_frame($sformatf("table%0d", t));
    end

    // Two back-to-back frames; avg_mode flips mid-frame and must only apply from the next frame.
    for (int r = 0; r < 2; r++) begin
      sel = 0;
      avg_mode = r[0];
      clear_q();
      gen_rand(288);
      build_expected(0, r[0], 0);
      build_expected(0, !r[0], 144);
      drive((r == 0) ? 30 : 0, 70, 144 + 50);
      settle();
      check_frame($sformatf("rand%0d", r));
    end

    sel = 0;
    avg_mode = 1'b0;
    clear_q();
    gen_rand(7);
    drive(0, -1, -1);
    #1;
    master_rst = 1'b1;
    #1;
    chk("midrst.data_out", 0, dout, 0);
    chk("midrst.valid_op", 0, vo, 0);
    chk("midrst.end_op", 0, eo, 0);
    @(posedge clk); #1;
    master_rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst.partial_pulses", 0, obs_val.size(), 0);
    clear_q();
    avg_mode = 1'b1;
    gen_rand(144);
    build_expected(0, 1'b1, 0);
    drive(0, -1, -1);
    settle();
    check_frame("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pool_unit.md
# pool_unit

Parametrised streaming 2-D pooling engine that replaces the fixed 3×3, 12-pixel-wide max pooler in the CNN accelerator datapath. It accepts a raster-order pixel stream from the convolution stage, one pixel per `ce` cycle. It produces one pooled result per non-overlapping POOL×POOL window and supports runtime-selectable max or average mode. Image width, height, pool size and data width are all parameters. Partial window results are held in an internal line buffer sized IMG_W/POOL, so no external shift RAM is needed.

## Interface
- DATA_W, 32, pixel width; two's-complement signed
- IMG_W, 12, input pixels per row
- IMG_H, 12, input rows per frame
- POOL, 3, window size and stride (POOL×POOL, non-overlapping); 2 ≤ POOL ≤ IMG_W and POOL ≤ IMG_H
- AVG_SHIFT, 3, arithmetic right shift applied to the window sum in average mode

- clk  in  1  sole clock; all logic is rising-edge
- master_rst  in  1  asynchronous, active-high reset
- ce  in  1  input pixel valid; one pixel is accepted per cycle with ce=1
- avg_mode  in  1  0 = max pooling, 1 = average pooling; sampled on the first pixel of each frame
- data_in  in  DATA_W  input pixel
- data_out  out  DATA_W  pooled result, registered
- valid_op  out  1  data_out valid, one-cycle pulse per window
- end_op  out  1  pulses together with valid_op on the last window of the frame

## Operation
- Counters (all advance only on ce=1):
  - col: 0..IMG_W-1
  - row: 0..IMG_H-1
  - hpos: 0..POOL-1, position inside the horizontal window
  - vpos: 0..POOL-1, window row
  - ocol: 0..OUT_W-1, where OUT_W = IMG_W/POOL (integer division)
- Trailing pixels are ignored:
  - Columns with col ≥ OUT_W·POOL are not accumulated.
  - Rows with row ≥ OUT_H·POOL (OUT_H = IMG_H/POOL) are not accumulated.
  - Counters still advance over these pixels.
- Horizontal accumulator hacc, width ACC_W = DATA_W + clog2(POOL·POOL):
  - hpos=0: hacc ← data_in (sign-extended).
  - Otherwise:
    - max mode: hacc ← max(hacc, data_in), signed compare.
    - avg mode: hacc ← hacc + data_in.
- Line buffer lb[OUT_W], each entry ACC_W bits. On hpos=POOL-1, let h = the combination of hacc and data_in:
  - vpos=0: lb[ocol] ← h.
  - 0<vpos<POOL-1: lb[ocol] ← combine(lb[ocol], h).
  - vpos=POOL-1: the final window value w = combine(lb[ocol], h) goes to the output stage. lb is not written.
- Output stage:
  - max mode: data_out ← w[DATA_W-1:0]. No overflow is possible.
  - avg mode: data_out ← sat(w >>> AVG_SHIFT). sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - valid_op ← 1 for one cycle.
- Frame control:
  - A frame is exactly IMG_W·IMG_H accepted pixels.
  - After the last pixel, all counters wrap to 0 and the next frame starts with no idle cycles required.
  - The mode is latched at col=0, row=0. A change of avg_mode mid-frame takes effect next frame.
- end_op is asserted with the valid_op for window (OUT_H-1, OUT_W-1).
- The FSM is implicit in the counters. A state register tracks IDLE (no pixel yet this frame) and ACTIVE; the state returns to IDLE when the frame wraps. IDLE and ACTIVE differ only in the mode latch.

## Timing
- Reset values:
  - data_out=0, valid_op=0, end_op=0.
  - All counters 0, state IDLE, latched mode = max.
  - lb contents are don't-care, because vpos=0 always overwrites them.
- Latency: valid_op and data_out update on the clock edge that accepts the last pixel of a window. They are visible one cycle after that ce cycle.
- valid_op is a single-cycle pulse. data_out holds its value until the next valid window.
- ce=0 stalls all state. Gaps of any length between pixels are legal and do not change results.
- Throughput: one pixel per cycle sustained. No backpressure exists; the downstream stage must accept every valid_op pulse.
- master_rst asserted mid-frame:
  - It immediately clears all outputs and counters.
  - The partial frame is discarded. The first pixel after release is treated as col=0, row=0.
- Simultaneous last-pixel-of-frame and first-pixel-of-next-frame across consecutive cycles: the output pulse of frame N and the accumulation for frame N+1 proceed with no interference.

## Test plan
- Max mode, IMG_W=IMG_H=4, POOL=2, inputs 0..15 raster, ce continuous -> valid_op pulses carry 5, 7, 13, 15; end_op only with 15; 4 pulses total.
- Avg mode, same configuration and stimulus, AVG_SHIFT=2 -> 2, 4, 10, 12 (sums 10, 18, 42, 50).
- Default parameters (12×12, POOL=3), max mode, signed data with all pixels -5 except one 7 per window -> 16 outputs of 7. Repeat with all pixels -5 -> 16 outputs of -5, confirming the signed compare.
- IMG_W=5, IMG_H=5, POOL=2, inputs 0..24 -> 4 outputs: 6, 8, 16, 18. Column 4 and row 4 are ignored; end_op is asserted with 18.
- Random ce gaps (30% idle), two back-to-back frames with avg_mode toggled mid-frame -> results identical to the gap-free run, and the mode changes only at the frame boundary.
- Assert master_rst for 1 cycle after 7 pixels of a frame, then a full frame -> outputs 0 during reset, no valid_op from the partial frame, and the full frame's results correct.
